// File: rtl/dec_pkg_v.sv
// Shared constants for the registered 3-to-8 decoder slice.
package dec_pkg_v;

  // Default code width and delivered-item counter width.
  localparam int unsigned IN_W_DEF  = 3;
  localparam int unsigned CNT_W_DEF = 8;

  // Output-stage occupancy state encodings.
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
  localparam logic [ST_W-1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/decoder_3_8_comb_v.sv
// Pure combinational {code, code_v} -> one-hot decode (inverse of the priority encoder).
module decoder_3_8_comb_v
  import dec_pkg_v::*;
#(
  parameter  int unsigned IN_W  = IN_W_DEF,
  localparam int unsigned OUT_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  code,
  input  logic             code_v,
  output logic [OUT_W-1:0] onehot
);

  // Select line for a valid code, nothing for an absent one.
  always_comb begin
    onehot = '0;
    if (code_v) begin
      onehot = OUT_W'(1) << code;
    end
  end

endmodule

// File: rtl/decoder_3_8_v.sv
// Registered 3-to-8 decoder with valid/ready on both sides, a 2-entry skid
// buffer and a wrap-around count of delivered non-zero decodes.
module decoder_3_8_v
  import dec_pkg_v::*;
#(
  parameter  int unsigned IN_W       = IN_W_DEF,
  parameter  int unsigned ACTIVE_LOW = 0,
  parameter  int unsigned CNT_W      = CNT_W_DEF,
  localparam int unsigned OUT_W      = 2 ** IN_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IN_W-1:0]  i_code,
  input  logic             i_code_v,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_onehot,
  output logic             o_zero,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count
);

  // Polarity applied before storage; idle vector is all-inactive lines.
  localparam logic             INV     = (ACTIVE_LOW != 0);
  localparam logic [OUT_W-1:0] IDLE_OH = {OUT_W{INV}};

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic             valid_q;
  logic             ready_q;

  logic [OUT_W-1:0] raw_onehot;
  logic [OUT_W-1:0] dec_onehot;
  logic             dec_zero;

  logic [OUT_W-1:0] out_onehot_q;
  logic             out_zero_q;
  logic [OUT_W-1:0] skid_onehot_q;
  logic             skid_zero_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic             take;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;

  decoder_3_8_comb_v #(
    .IN_W (IN_W)
  ) u_dec (
    .code   (i_code),
    .code_v (i_code_v),
    .onehot (raw_onehot)
  );

  // Input-side decode, polarity and zero flag.
  always_comb begin
    dec_onehot = raw_onehot ^ IDLE_OH;
    dec_zero   = ~i_code_v;
  end

  // Handshake events; o_ready comes from registered state only.
  always_comb begin
    accept = i_valid & ready_q;
    take   = valid_q & i_ready;
  end

  // Next-state and storage steering for the skid FSM.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_ONE;
          load_out = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !take) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (take && !accept) begin
          state_d = ST_EMPTY;
        end else if (take && accept) begin
          load_out = 1'b1;
        end
      end
      ST_TWO: begin
        // No accept possible here: ready is low while both entries are full.
        if (take) begin
          state_d       = ST_ONE;
          out_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State register with registered valid/ready flags derived from next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != ST_EMPTY);
      ready_q <= (state_d != ST_TWO);
    end
  end

  // OUT and SKID entries; reset discards anything held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_onehot_q  <= IDLE_OH;
      out_zero_q    <= 1'b0;
      skid_onehot_q <= IDLE_OH;
      skid_zero_q   <= 1'b0;
    end else begin
      if (load_out) begin
        out_onehot_q <= dec_onehot;
        out_zero_q   <= dec_zero;
      end else if (out_from_skid) begin
        out_onehot_q <= skid_onehot_q;
        out_zero_q   <= skid_zero_q;
      end
      if (load_skid) begin
        skid_onehot_q <= dec_onehot;
        skid_zero_q   <= dec_zero;
      end
    end
  end

  // Count delivered items that carried a valid code; wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (take && !out_zero_q) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_onehot = out_onehot_q;
  assign o_zero   = out_zero_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_decoder_3_8_v.sv
// Directed, table-driven bench for decoder_3_8_v (active-high and active-low copies).
module tb_decoder_3_8_v;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code;
  logic       code_v;
  logic       valid;
  logic       rdy;

  logic       o_ready, o_zero, o_valid;
  logic [7:0] o_onehot, o_count;
  logic       al_ready, al_zero, al_valid;
  logic [7:0] al_onehot, al_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_3_8_v #(.IN_W(3), .ACTIVE_LOW(0), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_v(code_v),
    .i_valid(valid), .o_ready(o_ready), .o_onehot(o_onehot),
    .o_zero(o_zero), .o_valid(o_valid), .i_ready(rdy), .o_count(o_count)
  );

  decoder_3_8_v #(.IN_W(3), .ACTIVE_LOW(1), .CNT_W(8)) dut_al (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_v(code_v),
    .i_valid(valid), .o_ready(al_ready), .o_onehot(al_onehot),
    .o_zero(al_zero), .o_valid(al_valid), .i_ready(rdy), .o_count(al_count)
  );

  typedef struct {
    logic [2:0] code;
    logic       code_v;
    logic [7:0] exp_oh;
    logic [7:0] exp_oh_al;
    logic       exp_zero;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] stream_exp [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream n items of one code back-to-back with i_ready=1, then drain.
  task automatic stream(input int n, input logic [2:0] c);
    code   = c;
    code_v = 1'b1;
    rdy    = 1'b1;
    valid  = 1'b1;
    for (int k = 0; k < n; k++) step();
    valid = 1'b0;
    step();
  endtask

  initial begin
    tbl[0] = '{3'd0, 1'b1, 8'h01, 8'hFE, 1'b0, 8'd1};
    tbl[1] = '{3'd1, 1'b1, 8'h02, 8'hFD, 1'b0, 8'd2};
    tbl[2] = '{3'd2, 1'b1, 8'h04, 8'hFB, 1'b0, 8'd3};
    tbl[3] = '{3'd3, 1'b1, 8'h08, 8'hF7, 1'b0, 8'd4};
    tbl[4] = '{3'd4, 1'b1, 8'h10, 8'hEF, 1'b0, 8'd5};
    tbl[5] = '{3'd5, 1'b1, 8'h20, 8'hDF, 1'b0, 8'd6};
    tbl[6] = '{3'd6, 1'b1, 8'h40, 8'hBF, 1'b0, 8'd7};
    tbl[7] = '{3'd7, 1'b1, 8'h80, 8'h7F, 1'b0, 8'd8};
    tbl[8] = '{3'd7, 1'b0, 8'h00, 8'hFF, 1'b1, 8'd8};
    tbl[9] = '{3'd2, 1'b0, 8'h00, 8'hFF, 1'b1, 8'd8};
    stream_exp[0] = 8'h01; stream_exp[1] = 8'h02;
    stream_exp[2] = 8'h04; stream_exp[3] = 8'h08;
    stream_exp[4] = 8'h10; stream_exp[5] = 8'h20;
    stream_exp[6] = 8'h40; stream_exp[7] = 8'h80;

    rst = 1'b1; code = 3'd0; code_v = 1'b0; valid = 1'b0; rdy = 1'b0;
    step(); step();
    check("rst_valid",  32'(o_valid),   32'd0);
    check("rst_ready",  32'(o_ready),   32'd1);
    check("rst_zero",   32'(o_zero),    32'd0);
    check("rst_onehot", 32'(o_onehot),  32'h00);
    check("rst_count",  32'(o_count),   32'd0);
    check("rst_al_oh",  32'(al_onehot), 32'hFF);
    rst = 1'b0;
    step();

    // Single transfers from empty: 1-cycle latency, count on take.
    for (int i = 0; i < 10; i++) begin
      code = tbl[i].code; code_v = tbl[i].code_v; valid = 1'b1; rdy = 1'b1;
      step();
      check($sformatf("tbl%0d_valid", i),  32'(o_valid),   32'd1);
      check($sformatf("tbl%0d_onehot", i), 32'(o_onehot),  32'(tbl[i].exp_oh));
      check($sformatf("tbl%0d_zero", i),   32'(o_zero),    32'(tbl[i].exp_zero));
      check($sformatf("tbl%0d_al_oh", i),  32'(al_onehot), 32'(tbl[i].exp_oh_al));
      check($sformatf("tbl%0d_al_zero", i), 32'(al_zero),  32'(tbl[i].exp_zero));
      valid = 1'b0;
      step();
      check($sformatf("tbl%0d_drained", i), 32'(o_valid),  32'd0);
      check($sformatf("tbl%0d_count", i),  32'(o_count),   32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_al_cnt", i), 32'(al_count),  32'(tbl[i].exp_cnt));
    end

    // Back-to-back stream of codes 0..7 at full throughput.
    valid = 1'b1; code_v = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      code = 3'(k);
      step();
      check($sformatf("strm%0d_onehot", k), 32'(o_onehot), 32'(stream_exp[k]));
      check($sformatf("strm%0d_ready", k),  32'(o_ready),  32'd1);
      check($sformatf("strm%0d_valid", k),  32'(o_valid),  32'd1);
    end
    valid = 1'b0;
    step();
    check("strm_drained", 32'(o_valid), 32'd0);
    check("strm_count",   32'(o_count), 32'd16);

    // Backpressure: codes 2 then 6 fill OUT and SKID.
    rdy = 1'b0; valid = 1'b1; code_v = 1'b1; code = 3'd2;
    step();
    check("bp_first_oh", 32'(o_onehot), 32'h04);
    check("bp_first_rdy", 32'(o_ready), 32'd1);
    code = 3'd6;
    step();
    check("bp_two_oh",    32'(o_onehot), 32'h04);
    check("bp_two_ready", 32'(o_ready),  32'd0);
    check("bp_two_valid", 32'(o_valid),  32'd1);
    code = 3'd1;  // offered while full; must be ignored
    step();
    check("bp_hold_oh",    32'(o_onehot), 32'h04);
    check("bp_hold_ready", 32'(o_ready),  32'd0);
    valid = 1'b0; rdy = 1'b1;
    step();
    check("bp_skid_oh",    32'(o_onehot), 32'h40);
    check("bp_skid_ready", 32'(o_ready),  32'd1);
    check("bp_skid_valid", 32'(o_valid),  32'd1);
    step();
    check("bp_empty_valid", 32'(o_valid), 32'd0);
    check("bp_count",       32'(o_count), 32'd18);
    step();
    check("bp_no_dup",      32'(o_valid), 32'd0);

    // Counter wrap: 18 + 237 = 255, then one more wraps to 0.
    stream(237, 3'd3);
    check("wrap_255",    32'(o_count),  32'd255);
    stream(1, 3'd5);
    check("wrap_0",      32'(o_count),  32'd0);
    check("wrap_al_0",   32'(al_count), 32'd0);

    // Reset while in TWO discards both entries and the pending take.
    stream(1, 3'd4);
    check("pre_rst_count", 32'(o_count), 32'd1);
    rdy = 1'b0; valid = 1'b1; code_v = 1'b1; code = 3'd1;
    step();
    code = 3'd7;
    step();
    check("pre_rst_ready", 32'(o_ready), 32'd0);
    rst = 1'b1; rdy = 1'b1; code = 3'd2;
    step();
    check("mid_rst_valid",  32'(o_valid),   32'd0);
    check("mid_rst_ready",  32'(o_ready),   32'd1);
    check("mid_rst_count",  32'(o_count),   32'd0);
    check("mid_rst_oh",     32'(o_onehot),  32'h00);
    check("mid_rst_zero",   32'(o_zero),    32'd0);
    check("mid_rst_al_oh",  32'(al_onehot), 32'hFF);
    rst = 1'b0; valid = 1'b0;
    step();
    step();
    check("post_rst_valid", 32'(o_valid), 32'd0);
    check("post_rst_count", 32'(o_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_3_8_v.md
Name: decoder_3_8_v

Overview:
- Registered 3-to-8 decoder. It reverses the 8-to-3 priority encoder path: a {code, valid} pair goes in, a one-hot line vector comes out.
- Sits downstream of the encoder datapath to regenerate select/enable lines. Uses valid/ready handshakes on both sides and a 2-entry skid buffer, so backpressure never drops or duplicates a code.
- Also keeps a wrap-around count of delivered non-zero decodes.

Parameters:
- IN_W, 3, code width; OUT_W = 2**IN_W is a derived localparam, not overridable.
- ACTIVE_LOW, 0, 1 inverts o_onehot (selected line driven 0, all others 1).
- CNT_W, 8, width of o_count.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_code  in  IN_W  code to decode.
- i_code_v  in  1  code-valid flag (encoder's "any input set"); 0 means decode to all-inactive.
- i_valid  in  1  upstream transfer request.
- o_ready  out  1  block can accept; depends only on internal state.
- o_onehot  out  OUT_W  decoded lines; meaningful only while o_valid=1.
- o_zero  out  1  delivered item had i_code_v=0; qualified by o_valid.
- o_valid  out  1  output item present.
- i_ready  in  1  downstream accepts.
- o_count  out  CNT_W  delivered items with code_v=1, modulo 2**CNT_W.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Handshake events:
  - accept = i_valid & o_ready.
  - take = o_valid & i_ready.
- Decode (combinational, at input side):
  - onehot = i_code_v ? (1 << i_code) : 0.
  - If ACTIVE_LOW=1, the vector is inverted before storage.
  - zero = ~i_code_v. i_code is don't-care when i_code_v=0.
- Storage: OUT reg (drives outputs) and SKID reg, each holding {onehot, zero}.
- FSM states (one-hot or binary, implementer's choice):
  - EMPTY: o_valid=0, o_ready=1.
  - ONE: o_valid=1, o_ready=1.
  - TWO: o_valid=1, o_ready=0.
- Transitions:
  - EMPTY: accept -> ONE, OUT<=decoded.
  - ONE: accept & ~take -> TWO, SKID<=decoded.
  - ONE: take & ~accept -> EMPTY.
  - ONE: accept & take -> ONE, OUT<=decoded.
  - ONE: neither -> hold.
  - TWO: take -> ONE, OUT<=SKID. accept is impossible in TWO.
- Timing and data integrity:
  - Latency is 1 cycle from accept to o_valid when the block is empty.
  - Sustained throughput is 1/cycle with i_ready=1.
  - Ordering is strictly FIFO. No loss or duplication under any i_ready pattern.
  - o_onehot and o_zero are stable while o_valid=1 and i_ready=0.
- Counter: o_count increments on take when the OUT entry has zero=0, and wraps from all-ones to 0. Items with zero=1 do not count.
- Reset values:
  - state EMPTY, o_valid=0, o_ready=1, o_zero=0, o_count=0.
  - o_onehot = all-0 (ACTIVE_LOW=0) or all-1 (ACTIVE_LOW=1).
  - SKID cleared the same way.
- Reset mid-operation: held or skidded items are discarded, with no take counted in the reset cycle. i_valid during reset is ignored.
- Inputs sampled while o_ready=0 are ignored. Upstream must hold i_valid/i_code until accepted.

Decomposition:
- Shared package/header dec_pkg_v holds:
  - IN_W default.
  - FSM state encodings ST_EMPTY/ST_ONE/ST_TWO.
  - CNT_W default.
- Sub-module decoder_3_8_comb_v: pure combinational {code, code_v} -> onehot. This is the encoder's inverse, kept reusable for unregistered paths.

Test Plan:
- Reset then i_valid=1, i_code=3'b101, i_code_v=1, i_ready=1 -> next cycle o_valid=1, o_onehot=8'h20, o_zero=0; cycle after, o_count=1.
- Stream codes 0..7, all code_v=1, i_ready=1 -> o_onehot sequence 01,02,04,...,80 back-to-back; o_ready stays 1; final o_count=8.
- i_ready=0 while sending codes 2 then 6 -> o_onehot holds 8'h04, state TWO, o_ready=0. Raise i_ready -> 8'h04 then 8'h40 delivered in order, o_ready returns 1.
- i_code_v=0, i_code=3'b111 -> o_onehot=8'h00, o_zero=1, o_count unchanged. With ACTIVE_LOW=1, code 3 -> o_onehot=8'hF7.
- Preload o_count=255 via 255 transfers, then one more code_v=1 transfer -> o_count=0.
- Assert i_rst while in TWO -> next cycle o_valid=0, o_ready=1, o_count=0; the skidded item is never delivered.
